// File: rtl/video_timing_gen.sv
// Raster timing generator for the 27 MHz pixel clock (default CEA-861 720x480p60).
// Registered hs/vs/de, pixel coordinates, frame start and a leading line-fetch request.
module video_timing_gen #(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 62,
  parameter int H_BP     = 60,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 30,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LEAD     = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        line_req,
  output logic [10:0] line_y
);

  localparam logic [10:0] H_TOT    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_TOT    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] REQ_X    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - LEAD);
  localparam logic        HS_ON    = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic        VS_ON    = (VS_POL != 0) ? 1'b1 : 1'b0;

  logic [10:0] x_r, y_r, line_y_r;
  logic        hs_r, vs_r, de_r, fs_r, lr_r;

  logic        idle_s;
  logic [10:0] nx_s, ny_s, req_line_s;
  logic        de_s, hs_act_s, vs_act_s, fs_s, lr_s;

  // Only the idle state sits at (0,0) without frame_start, so no separate run flag is needed.
  assign idle_s = (x_r == 11'd0) && (y_r == 11'd0) && !fs_r;

  // Next raster position: restart at (0,0) out of idle, otherwise advance with wrap.
  always_comb begin
    nx_s = 11'd0;
    ny_s = 11'd0;
    if (idle_s) begin
      nx_s = 11'd0;
      ny_s = 11'd0;
    end else if (x_r == H_TOT - 11'd1) begin
      nx_s = 11'd0;
      if (y_r == V_TOT - 11'd1) begin
        ny_s = 11'd0;
      end else begin
        ny_s = y_r + 11'd1;
      end
    end else begin
      nx_s = x_r + 11'd1;
      ny_s = y_r;
    end
  end

  // Decode the next position so every registered output describes the same (x,y).
  always_comb begin
    req_line_s = 11'd0;
    if (ny_s == V_TOT - 11'd1) begin
      req_line_s = 11'd0;
    end else begin
      req_line_s = ny_s + 11'd1;
    end
    de_s     = (nx_s < H_ACT) && (ny_s < V_ACT);
    hs_act_s = (nx_s >= HS_START) && (nx_s < HS_END);
    // vs edges are aligned to the hs leading edge of the first and last sync lines.
    vs_act_s = ((ny_s == VS_START) && (nx_s >= HS_START)) ||
               ((ny_s > VS_START) && (ny_s < VS_END)) ||
               ((ny_s == VS_END) && (nx_s < HS_START));
    fs_s     = (nx_s == 11'd0) && (ny_s == 11'd0);
    lr_s     = (nx_s == REQ_X) && (req_line_s < V_ACT);
  end

  // Output registers; reset and disable both force the idle values.
  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      x_r      <= 11'd0;
      y_r      <= 11'd0;
      de_r     <= 1'b0;
      hs_r     <= ~HS_ON;
      vs_r     <= ~VS_ON;
      fs_r     <= 1'b0;
      lr_r     <= 1'b0;
      line_y_r <= 11'd0;
    end else begin
      x_r  <= nx_s;
      y_r  <= ny_s;
      de_r <= de_s;
      hs_r <= hs_act_s ? HS_ON : ~HS_ON;
      vs_r <= vs_act_s ? VS_ON : ~VS_ON;
      fs_r <= fs_s;
      lr_r <= lr_s;
      if (lr_s) begin
        line_y_r <= req_line_s;
      end else begin
        line_y_r <= line_y_r;
      end
    end
  end

  assign x           = x_r;
  assign y           = y_r;
  assign de          = de_r;
  assign hs          = hs_r;
  assign vs          = vs_r;
  assign frame_start = fs_r;
  assign line_req    = lr_r;
  assign line_y      = line_y_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a reduced raster (16x11, LEAD=4) checked cycle by cycle,
// plus the default 858x525 timing checked over its first two lines.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic        s_hs, s_vs, s_de, s_fs, s_lr;
  logic [10:0] s_x, s_y, s_ly;
  logic        b_hs, b_vs, b_de, b_fs, b_lr;
  logic [10:0] b_x, b_y, b_ly;

  // Small raster: H 8+2+3+3=16, V 6+1+2+2=11, line_req at x=12.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(0), .VS_POL(0), .LEAD(4)
  ) dut_small (
    .clk(clk), .resetn(resetn), .en(en),
    .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .frame_start(s_fs), .line_req(s_lr), .line_y(s_ly)
  );

  video_timing_gen dut_big (
    .clk(clk), .resetn(resetn), .en(en),
    .hs(b_hs), .vs(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .frame_start(b_fs), .line_req(b_lr), .line_y(b_ly)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        lr;
    logic [10:0] ly;
  } obs_t;

  typedef struct {
    logic rn;
    logic e;
    obs_t exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  bit          m_run = 1'b0;
  int          mx = 0;
  int          my = 0;
  logic [10:0] m_ly = 11'd0;

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected outputs of the small raster at (px,py); ly holds the line a request here would name.
  function automatic obs_t mk(int px, int py);
    obs_t o;
    int nl;
    o.x  = 11'(px);
    o.y  = 11'(py);
    o.de = (px < 8) && (py < 6);
    o.hs = !((px >= 10) && (px <= 12));
    o.vs = !(((py == 7) && (px >= 10)) || (py == 8) || ((py == 9) && (px < 10)));
    o.fs = (px == 0) && (py == 0);
    nl   = (py == 10) ? 0 : py + 1;
    o.lr = (px == 12) && (nl < 6);
    o.ly = 11'(nl);
    return o;
  endfunction

  function automatic obs_t small_obs();
    obs_t o;
    o.x = s_x; o.y = s_y; o.de = s_de; o.hs = s_hs; o.vs = s_vs;
    o.fs = s_fs; o.lr = s_lr; o.ly = s_ly;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b lr=%b ly=%0d, expected x=%0d y=%0d de=%b hs=%b vs=%b fs=%b lr=%b ly=%0d",
               name, act.x, act.y, act.de, act.hs, act.vs, act.fs, act.lr, act.ly,
               exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.fs, exp.lr, exp.ly);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock on the small raster with the model stepped alongside.
  task automatic cyc(input logic rn, input logic e);
    obs_t exp;
    resetn = rn;
    en = e;
    @(posedge clk);
    #1;
    if (!rn || !e) begin
      m_run = 1'b0; mx = 0; my = 0; m_ly = 11'd0;
      exp = idle_obs();
    end else begin
      if (!m_run) begin
        m_run = 1'b1; mx = 0; my = 0;
      end else if (mx == 15) begin
        mx = 0;
        my = (my == 10) ? 0 : my + 1;
      end else begin
        mx++;
      end
      exp = mk(mx, my);
      if (exp.lr) m_ly = exp.ly;
      exp.ly = m_ly;
    end
    check_obs($sformatf("pos(%0d,%0d) rn=%b en=%b", mx, my, rn, e), small_obs(), exp);
  endtask

  vec_t vecs[10];

  initial begin
    int de_cnt, hs_cnt, vs_cnt, lr_cnt, fs_cnt, fs_first, fs_second, guard;
    int hs_first, de_last, conflict, lr_x, lr_ly;

    vecs[0] = '{1'b0, 1'b1, idle_obs()};
    vecs[1] = '{1'b1, 1'b0, idle_obs()};
    vecs[2] = '{1'b1, 1'b1, mk(0, 0)};
    vecs[3] = '{1'b1, 1'b1, mk(1, 0)};
    vecs[4] = '{1'b1, 1'b0, idle_obs()};
    vecs[5] = '{1'b1, 1'b1, mk(0, 0)};
    vecs[6] = '{1'b0, 1'b1, idle_obs()};
    vecs[7] = '{1'b1, 1'b1, mk(0, 0)};
    vecs[8] = '{1'b1, 1'b1, mk(1, 0)};
    vecs[9] = '{1'b1, 1'b0, idle_obs()};
    for (int i = 2; i < 9; i++) begin
      if (vecs[i].rn && vecs[i].e) vecs[i].exp.ly = 11'd0;
    end

    for (int i = 0; i < 10; i++) begin
      resetn = vecs[i].rn;
      en = vecs[i].e;
      @(posedge clk);
      #1;
      check_obs($sformatf("vec%0d", i), small_obs(), vecs[i].exp);
    end
    m_run = 1'b0; mx = 0; my = 0; m_ly = 11'd0;

    // Two full frames from a fresh start, every cycle compared, plus aggregates.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; lr_cnt = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int i = 0; i < 352; i++) begin
      cyc(1'b1, 1'b1);
      if (s_de) de_cnt++;
      if (!s_hs) hs_cnt++;
      if (!s_vs) vs_cnt++;
      if (s_lr) lr_cnt++;
      if (s_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
      end
    end
    check_int("de_cycles_2frames", de_cnt, 96);
    check_int("hs_low_2frames", hs_cnt, 66);
    check_int("vs_low_2frames", vs_cnt, 64);
    check_int("line_req_2frames", lr_cnt, 12);
    check_int("frame_start_count", fs_cnt, 2);
    check_int("frame_start_period", fs_second - fs_first, 176);

    // en dropped while both syncs are asserted, idle for 10 cycles, then restart.
    guard = 0;
    while (!(mx == 11 && my == 7) && guard < 400) begin
      cyc(1'b1, 1'b1);
      guard++;
    end
    check_int("reach_11_7", guard < 400 ? 1 : 0, 1);
    check_int("syncs_low_at_11_7", {31'd0, (!s_hs && !s_vs)}, 1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check_int("restart_after_en_fs", {31'd0, s_fs}, 1);

    // One-cycle reset pulse during vsync, then restart.
    guard = 0;
    while (!(mx == 2 && my == 8) && guard < 400) begin
      cyc(1'b1, 1'b1);
      guard++;
    end
    check_int("reach_2_8", guard < 400 ? 1 : 0, 1);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);

    // Default 720x480p60 timing over its first two lines.
    en = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_int("big_idle_hs", {31'd0, b_hs}, 1);
    check_int("big_idle_de", {31'd0, b_de}, 0);
    en = 1'b1;
    de_cnt = 0; hs_cnt = 0; lr_cnt = 0; hs_first = -1; de_last = -1; conflict = 0;
    lr_x = -1; lr_ly = -1;
    for (int i = 0; i < 1716; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        check_int("big_first_x", int'(b_x), 0);
        check_int("big_first_y", int'(b_y), 0);
        check_int("big_first_fs_de", {30'd0, b_fs, b_de}, 3);
      end
      if (i == 858) begin
        check_int("big_line1_x", int'(b_x), 0);
        check_int("big_line1_y", int'(b_y), 1);
      end
      if (i < 858) begin
        if (b_de) begin de_cnt++; de_last = i; end
        if (!b_hs) begin hs_cnt++; if (hs_first < 0) hs_first = i; end
        if (b_lr) begin lr_x = int'(b_x); lr_ly = int'(b_ly); end
      end
      if (!b_hs && b_de) conflict++;
      if (b_lr) lr_cnt++;
    end
    check_int("big_de_count_line0", de_cnt, 720);
    check_int("big_de_last_x", de_last, 719);
    check_int("big_hs_first_x", hs_first, 736);
    check_int("big_hs_low_line0", hs_cnt, 62);
    check_int("big_hs_during_de", conflict, 0);
    check_int("big_line_req_x", lr_x, 794);
    check_int("big_line_req_ly", lr_ly, 1);
    check_int("big_line_req_count", lr_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
